// File: rtl/mrd_out_scale.sv
// DFT output stage: applies the packet block exponent as a rounded, saturating shift and regenerates sop/eop framing.
// Latency 2 cycles, one sample per clock, no backpressure; malformed packets flagged with one-cycle pulses.
module mrd_out_scale #(
  parameter int OUT_W = 16,
  parameter int EXP_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic signed [17:0]      in_real,
  input  logic signed [17:0]      in_imag,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [11:0]             in_dftpts,
  output logic                    out_valid,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic signed [OUT_W-1:0] out_real,
  output logic signed [OUT_W-1:0] out_imag,
  output logic signed [EXP_W-1:0] out_exp,
  output logic                    err_short,
  output logic                    err_orphan,
  output logic                    sat_flag
);

  typedef enum logic {ST_IDLE, ST_PKT} state_t;

  localparam logic signed [35:0] C_I_MAX = 36'sd16777215;
  localparam logic signed [35:0] C_I_MIN = -36'sd16777216;
  localparam logic signed [24:0] C_MAX   = 25'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [24:0] C_MIN   = -C_MAX - 25'sd1;

  state_t                  r_state, w_state_nxt;
  logic [11:0]             r_cnt, w_cnt_nxt;
  logic [11:0]             r_len, w_len_nxt;
  logic signed [EXP_W-1:0] r_exp, w_exp_nxt;
  logic                    w_emit, w_sop, w_eop, w_err_short, w_err_orphan;
  logic signed [EXP_W-1:0] w_s;

  logic                    r1_vld, r1_sop, r1_eop, r1_short, r1_orph;
  logic signed [EXP_W-1:0] r1_exp;
  logic signed [24:0]      r1_re, r1_im;
  logic [OUT_W:0]          w_re_sat, w_im_sat;

  // Shift result is pre-clamped to 25 bits; this cannot change the final
  // OUT_W saturation because OUT_W never exceeds 18.
  function automatic logic signed [24:0] scale_fn(input logic signed [17:0] x,
                                                  input logic signed [EXP_W-1:0] s);
    logic signed [7:0]  se;
    logic signed [7:0]  mag;
    logic [5:0]         k;
    logic signed [35:0] wide;
    se  = 8'(s);
    mag = -se;
    if (se >= 8'sd0) begin
      k    = (se > 8'sd18) ? 6'd18 : 6'(se);
      wide = 36'(x) <<< k;
    end else begin
      k    = (mag > 8'sd18) ? 6'd18 : 6'(mag);
      wide = (36'(x) + (36'sd1 <<< (k - 6'd1))) >>> k;
    end
    if (wide > C_I_MAX)      scale_fn = C_I_MAX[24:0];
    else if (wide < C_I_MIN) scale_fn = C_I_MIN[24:0];
    else                     scale_fn = wide[24:0];
  endfunction

  // Returns {saturated, value}.
  function automatic logic [OUT_W:0] sat_fn(input logic signed [24:0] x);
    if (x > C_MAX)      sat_fn = {1'b1, C_MAX[OUT_W-1:0]};
    else if (x < C_MIN) sat_fn = {1'b1, C_MIN[OUT_W-1:0]};
    else                sat_fn = {1'b0, x[OUT_W-1:0]};
  endfunction

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_len_nxt    = r_len;
    w_exp_nxt    = r_exp;
    w_emit       = 1'b0;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_err_short  = 1'b0;
    w_err_orphan = 1'b0;
    if (in_valid) begin
      if (in_sop && in_dftpts != 12'd0) begin
        w_emit      = 1'b1;
        w_sop       = 1'b1;
        w_err_short = (r_state == ST_PKT);
        w_exp_nxt   = in_exp;
        w_len_nxt   = in_dftpts;
        w_cnt_nxt   = 12'd1;
        if (in_dftpts == 12'd1) begin
          w_eop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PKT;
        end
      end else if (in_sop || r_state == ST_IDLE) begin
        // Zero-length sop or a sample outside any packet is dropped.
        w_err_orphan = 1'b1;
        w_state_nxt  = ST_IDLE;
      end else begin
        w_emit    = 1'b1;
        w_cnt_nxt = r_cnt + 12'd1;
        if (r_cnt + 12'd1 == r_len) begin
          w_eop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
    end
  end

  assign w_s = (in_valid && in_sop) ? in_exp : r_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_exp    <= '0;
      r1_vld   <= 1'b0;
      r1_sop   <= 1'b0;
      r1_eop   <= 1'b0;
      r1_short <= 1'b0;
      r1_orph  <= 1'b0;
      r1_exp   <= '0;
      r1_re    <= '0;
      r1_im    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_len    <= w_len_nxt;
      r_exp    <= w_exp_nxt;
      r1_vld   <= w_emit;
      r1_sop   <= w_sop;
      r1_eop   <= w_eop;
      r1_short <= w_err_short;
      r1_orph  <= w_err_orphan;
      r1_exp   <= w_s;
      r1_re    <= scale_fn(in_real, w_s);
      r1_im    <= scale_fn(in_imag, w_s);
    end
  end

  assign w_re_sat = sat_fn(r1_re);
  assign w_im_sat = sat_fn(r1_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      out_real   <= '0;
      out_imag   <= '0;
      out_exp    <= '0;
      err_short  <= 1'b0;
      err_orphan <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      out_valid  <= r1_vld;
      out_sop    <= r1_sop;
      out_eop    <= r1_eop;
      err_short  <= r1_short;
      err_orphan <= r1_orph;
      sat_flag   <= r1_vld & (w_re_sat[OUT_W] | w_im_sat[OUT_W]);
      if (r1_vld) begin
        out_real <= w_re_sat[OUT_W-1:0];
        out_imag <= w_im_sat[OUT_W-1:0];
      end
      if (r1_vld && r1_sop) out_exp <= r1_exp;
    end
  end

endmodule

// File: tb/tb_mrd_out_scale.sv
// Bench for mrd_out_scale: directed scenarios plus random traffic, checked against a packet-level reference model.
module tb_mrd_out_scale;
  localparam int OUT_W = 16;
  localparam int EXP_W = 5;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid, in_sop;
  logic signed [17:0]      in_real, in_imag;
  logic signed [EXP_W-1:0] in_exp;
  logic [11:0]             in_dftpts;
  logic                    out_valid, out_sop, out_eop;
  logic signed [OUT_W-1:0] out_real, out_imag;
  logic signed [EXP_W-1:0] out_exp;
  logic                    err_short, err_orphan, sat_flag;

  mrd_out_scale #(.OUT_W(OUT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_real(in_real), .in_imag(in_imag), .in_exp(in_exp), .in_dftpts(in_dftpts),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_real(out_real), .out_imag(out_imag), .out_exp(out_exp),
    .err_short(err_short), .err_orphan(err_orphan), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit vld, sop, eop, es, eo, sat;
    int re, im, ex;
  } slot_t;

  slot_t q[$];
  int    checks = 0;
  int    errors = 0;
  // Reference model state: packet open flag, samples still owed, packet exponent.
  bit    m_in_pkt = 0;
  int    m_left   = 0;
  int    m_exp    = 0;
  int    m_outexp = 0;

  function automatic longint floordiv(input longint a, input longint d);
    longint r;
    r = a / d;
    if ((a % d) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic int scale(input int v, input int s, output bit sat);
    longint t, hi, lo;
    int     k;
    k  = (s < 0) ? -s : s;
    if (k > 18) k = 18;
    if (s >= 0) t = longint'(v) * (longint'(1) << k);
    else        t = floordiv(longint'(v) + (longint'(1) << (k - 1)), longint'(1) << k);
    hi  = (longint'(1) << (OUT_W - 1)) - 1;
    lo  = -(longint'(1) << (OUT_W - 1));
    sat = (t > hi) || (t < lo);
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    return int'(t);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input slot_t e);
    chk("out_valid",  int'(out_valid),  int'(e.vld));
    chk("out_sop",    int'(out_sop),    int'(e.sop));
    chk("out_eop",    int'(out_eop),    int'(e.eop));
    chk("err_short",  int'(err_short),  int'(e.es));
    chk("err_orphan", int'(err_orphan), int'(e.eo));
    chk("sat_flag",   int'(sat_flag),   int'(e.sat));
    chk("out_exp",    int'(out_exp),    e.ex);
    if (e.vld) begin
      chk("out_real", int'(out_real), e.re);
      chk("out_imag", int'(out_imag), e.im);
    end
  endtask

  task automatic check_reset_zero();
    chk("rst_valid", int'(out_valid),  0);
    chk("rst_sop",   int'(out_sop),    0);
    chk("rst_eop",   int'(out_eop),    0);
    chk("rst_real",  int'(out_real),   0);
    chk("rst_imag",  int'(out_imag),   0);
    chk("rst_exp",   int'(out_exp),    0);
    chk("rst_short", int'(err_short),  0);
    chk("rst_orph",  int'(err_orphan), 0);
    chk("rst_sat",   int'(sat_flag),   0);
  endtask

  function automatic slot_t model(input bit v, input bit s, input int re, input int im,
                                  input int ex, input int pts);
    slot_t e;
    bit    sr, si;
    e = '{default: 0};
    if (v) begin
      if (s && pts != 0) begin
        e.es     = m_in_pkt;
        e.vld    = 1;
        e.sop    = 1;
        m_exp    = ex;
        m_outexp = ex;
        m_left   = pts - 1;
        e.eop    = (m_left == 0);
        m_in_pkt = (m_left != 0);
      end else if (s || !m_in_pkt) begin
        e.eo     = 1;
        m_in_pkt = 0;
      end else begin
        e.vld  = 1;
        m_left = m_left - 1;
        e.eop  = (m_left == 0);
        if (e.eop) m_in_pkt = 0;
      end
      if (e.vld) begin
        e.re  = scale(re, m_exp, sr);
        e.im  = scale(im, m_exp, si);
        e.sat = sr | si;
      end
    end
    e.ex = m_outexp;
    return e;
  endfunction

  task automatic step(input bit v, input bit s, input int re, input int im,
                      input int ex, input int pts);
    @(negedge clk);
    if (q.size() == 2) compare(q.pop_front());
    in_valid  = v;
    in_sop    = s;
    in_real   = 18'(re);
    in_imag   = 18'(im);
    in_exp    = EXP_W'(ex);
    in_dftpts = 12'(pts);
    q.push_back(model(v, s, re, im, ex, pts));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int re, im, ex, pts;
    bit v, s;
    rst_n = 1'b0; in_valid = 0; in_sop = 0; in_real = '0; in_imag = '0;
    in_exp = '0; in_dftpts = '0;
    #3;
    check_reset_zero();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Nominal 12-point ramp, exponent 0.
    for (int i = 0; i < 12; i++) step(1, i == 0, i, -i, 0, 12);
    idle(2);
    // Negative exponent rounding: 5,6,-6,-7 -> 1,2,-1,-2.
    step(1, 1, 5, -5, -2, 4);
    step(1, 0, 6, -6, 0, 0);
    step(1, 0, -6, 6, 0, 0);
    step(1, 0, -7, 7, 0, 0);
    idle(2);
    // Saturation on a single-sample packet.
    step(1, 1, 5000, -5000, 3, 1);
    idle(2);
    // Truncation: 8-point packet cut after 5 samples by a 4-point packet.
    for (int i = 0; i < 5; i++) step(1, i == 0, 100 + i, i, 1, 8);
    for (int i = 0; i < 4; i++) step(1, i == 0, 200 + i, -i, -1, 4);
    idle(2);
    // Orphans, zero-length sop, then a 1-point packet.
    step(1, 0, 7, 7, 0, 0);
    step(1, 0, 8, 8, 0, 0);
    step(1, 1, 9, 9, 2, 0);
    step(1, 1, 10, -10, 2, 1);
    idle(2);

    // Asynchronous reset mid-packet with valid gaps.
    step(1, 1, 11, 11, 0, 10);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 12, 12, 0, 0);
    step(1, 0, 13, 13, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_reset_zero();
    q.delete();
    m_in_pkt = 0; m_left = 0; m_exp = 0; m_outexp = 0;
    @(negedge clk); in_valid = 1; in_sop = 0;
    @(negedge clk); in_valid = 0;
    check_reset_zero();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1, i == 0, 300 + i, 3 * i, -3, 3);
    idle(2);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      s  = m_in_pkt ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 4) != 0);
      re = int'($urandom_range(0, 262143)) - 131072;
      im = int'($urandom_range(0, 262143)) - 131072;
      ex = int'($urandom_range(0, 31)) - 16;
      pts = m_in_pkt ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 12));
      step(v, s, re, im, ex, pts);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
